mfu_cmd_frontend: RTL and testbench

- Input-side front end for the MFU datapath. Takes raw push-buttons and the 8-bit switch bus, then synchronizes and debounces them.
- Turns each debounced press into one command, issued over a valid/ready handshake that the compute/display core consumes.
- Replaces ad-hoc per-mode debounce in the core with one clean command stream carrying operand or opcode data.

---
 rtl/mfu_cmd_frontend.sv | 222 ++++++++++++++++++++++
 tb/tb_mfu_cmd_frontend.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfu_cmd_frontend.sv
// mfu_cmd_frontend
//   Input-side front end for the MFU datapath. Raw push-buttons and the
//   8-bit switch bus are synchronized; each button is debounced on its own;
//   every debounced press becomes one command offered over valid/ready.
//
// Ports
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset, clears every register
//   btn_num1     raw button, command 0 (NUM1, payload = switches)
//   btn_num2     raw button, command 1 (NUM2, payload = switches)
//   btn_compute  raw button, command 2 (COMPUTE, payload = switches)
//   btn_display  raw button, command 3 (DISPLAY, payload = 0)
//   btn_reset    raw button, command 4 (RESET, payload = 0, flushes others)
//   switch_bus   raw switches, synchronized only
//   cmd_ready    consumer accepts the offered command at this edge
//   cmd_valid    command offered
//   cmd_code     command code
//   cmd_data     command payload
//   drop_count   (only with MFU_CMD_DROP_COUNT_EN) saturating count of
//                dropped edges and of pending presses flushed by RESET
//
// Build option
//   MFU_CMD_DROP_COUNT_EN  adds the drop_count output and its counter.

module mfu_cmd_frontend #(
  parameter int unsigned         DB_WIDTH = 26,
  parameter logic [DB_WIDTH-1:0] DB_LIMIT = 26'h3FF_FFFF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       btn_num1,
  input  logic       btn_num2,
  input  logic       btn_compute,
  input  logic       btn_display,
  input  logic       btn_reset,
  input  logic [7:0] switch_bus,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic [7:0] cmd_data
`ifdef MFU_CMD_DROP_COUNT_EN
  ,
  output logic [7:0] drop_count
`endif
);

  localparam int NBTN = 5;
  localparam logic [DB_WIDTH-1:0] DB_ONE  = 1;
  localparam logic [DB_WIDTH-1:0] DB_LAST = DB_LIMIT - DB_ONE;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } state_t;

  // Bit order matches the command code: bit n issues code n.
  logic [NBTN-1:0]     btn_raw;
  logic [NBTN-1:0]     btn_sync_p0;
  logic [NBTN-1:0]     btn_sync_p1;
  logic [7:0]          sw_sync_p0;
  logic [7:0]          sw_sync_p1;
  logic [DB_WIDTH-1:0] db_cnt [NBTN];
  logic [NBTN-1:0]     db_lvl_p2;
  logic [NBTN-1:0]     db_lvl_p3;
  logic [NBTN-1:0]     rise_p3;
  logic [NBTN-1:0]     pending;
  logic [NBTN-1:0]     clr_mask;
  state_t              state_q;
  state_t              state_d;
  logic                issue;
  logic [2:0]          sel_code;
  logic [7:0]          sel_data;

  assign btn_raw = {btn_reset, btn_display, btn_compute, btn_num2, btn_num1};

`ifdef MFU_CMD_DROP_COUNT_EN
  function automatic logic [3:0] pop5(input logic [NBTN-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < NBTN; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] acc, input logic [3:0] inc);
    logic [8:0] s;
    s = {1'b0, acc} + {5'b00000, inc};
    return s[8] ? 8'hFF : s[7:0];
  endfunction
`endif

  // Stage p0/p1: two-flop synchronizers for buttons and switches
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      btn_sync_p0 <= '0;
      btn_sync_p1 <= '0;
      sw_sync_p0  <= '0;
      sw_sync_p1  <= '0;
    end else begin
      btn_sync_p0 <= btn_raw;
      btn_sync_p1 <= btn_sync_p0;
      sw_sync_p0  <= switch_bus;
      sw_sync_p1  <= sw_sync_p0;
    end
  end

  // Stage p2: per-button debounce; level follows after DB_LIMIT differing cycles
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NBTN; i++) begin
        db_cnt[i] <= '0;
      end
      db_lvl_p2 <= '0;
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        if (btn_sync_p1[i] == db_lvl_p2[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_lvl_p2[i] <= btn_sync_p1[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_ONE;
        end
      end
    end
  end

  // Stage p3: rising-edge capture into one pending bit per button
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      db_lvl_p3 <= '0;
    end else begin
      db_lvl_p3 <= db_lvl_p2;
    end
  end

  assign rise_p3 = db_lvl_p2 & ~db_lvl_p3;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | rise_p3;
    end
  end

  // Stage p4: issue FSM, fixed priority RESET > NUM1 > NUM2 > COMPUTE > DISPLAY
  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    sel_code = 3'd0;
    clr_mask = '0;
    case (state_q)
      S_IDLE: begin
        if (|pending) begin
          issue   = 1'b1;
          state_d = S_OFFER;
          if (pending[4]) begin
            sel_code = 3'd4;
            clr_mask = 5'b11111;
          end else if (pending[0]) begin
            sel_code = 3'd0;
            clr_mask = 5'b00001;
          end else if (pending[1]) begin
            sel_code = 3'd1;
            clr_mask = 5'b00010;
          end else if (pending[2]) begin
            sel_code = 3'd2;
            clr_mask = 5'b00100;
          end else begin
            sel_code = 3'd3;
            clr_mask = 5'b01000;
          end
        end
      end
      S_OFFER: begin
        if (cmd_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sel_data = (sel_code <= 3'd2) ? sw_sync_p1 : 8'h00;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cmd_valid <= 1'b0;
      cmd_code  <= '0;
      cmd_data  <= '0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        cmd_valid <= 1'b1;
        cmd_code  <= sel_code;
        cmd_data  <= sel_data;
      end else if (state_q == S_OFFER && cmd_ready) begin
        cmd_valid <= 1'b0;
      end
    end
  end

`ifdef MFU_CMD_DROP_COUNT_EN
  logic [NBTN-1:0] dropped;
  logic [NBTN-1:0] flushed;

  assign dropped = rise_p3 & pending & ~clr_mask;
  assign flushed = (issue && sel_code == 3'd4) ? (pending & 5'b01111) : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= '0;
    end else begin
      drop_count <= sat_add8(drop_count, pop5(dropped) + pop5(flushed));
    end
  end
`endif

endmodule

// File: tb/tb_mfu_cmd_frontend.sv
// tb_mfu_cmd_frontend
//   Bench for mfu_cmd_frontend with DB_LIMIT = 4. Expected commands go into a
//   queue when a press is driven; a monitor pops and compares on each transfer.
//   Table vectors cover one clean press per button; hand sequences cover
//   bounce, backpressure, priority/flush, async reset and re-press.

module tb_mfu_cmd_frontend;

  logic       clock;
  logic       reset_n;
  logic [4:0] btn;
  logic [7:0] switch_bus;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic [7:0] cmd_data;
`ifdef MFU_CMD_DROP_COUNT_EN
  logic [7:0] drop_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  logic [10:0] sb [$];

  mfu_cmd_frontend #(
    .DB_WIDTH (26),
    .DB_LIMIT (26'd4)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .btn_num1    (btn[0]),
    .btn_num2    (btn[1]),
    .btn_compute (btn[2]),
    .btn_display (btn[3]),
    .btn_reset   (btn[4]),
    .switch_bus  (switch_bus),
    .cmd_ready   (cmd_ready),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .cmd_data    (cmd_data)
`ifdef MFU_CMD_DROP_COUNT_EN
    ,
    .drop_count  (drop_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Scoreboard monitor: a transfer happens on the next rising edge.
  always @(negedge clock) begin
    if (reset_n && cmd_valid && cmd_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_cmd: got code %0d data 0x%0h expected none", cmd_code, cmd_data);
      end else begin
        logic [10:0] e;
        e = sb.pop_front();
        check("cmd_transfer", {21'd0, cmd_code, cmd_data}, {21'd0, e});
      end
    end
  end

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60 && sb.size() > 0; i++) step();
    check(name, sb.size(), 0);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int k;
    k = 0;
    while (!cmd_valid && k < budget) begin
      step();
      k++;
    end
    check(name, cmd_valid, 1'b1);
  endtask

  typedef struct {
    logic [4:0] btn;
    logic [7:0] sw;
    logic [2:0] code;
    logic [7:0] data;
  } vec_t;

  vec_t vecs [5];
  int   bounce [8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int seen;

    vecs[0] = '{btn: 5'b00001, sw: 8'hA5, code: 3'd0, data: 8'hA5};
    vecs[1] = '{btn: 5'b00010, sw: 8'h5A, code: 3'd1, data: 8'h5A};
    vecs[2] = '{btn: 5'b00100, sw: 8'h03, code: 3'd2, data: 8'h03};
    vecs[3] = '{btn: 5'b01000, sw: 8'h77, code: 3'd3, data: 8'h00};
    vecs[4] = '{btn: 5'b10000, sw: 8'hC3, code: 3'd4, data: 8'h00};
    bounce  = '{1, 2, 3, 1, 2, 1, 3, 2};

    reset_n    = 1'b0;
    btn        = '0;
    switch_bus = '0;
    cmd_ready  = 1'b1;
    step(3);
    check("rst_valid", cmd_valid, 1'b0);
    check("rst_code", cmd_code, 3'd0);
    check("rst_data", cmd_data, 8'h00);
`ifdef MFU_CMD_DROP_COUNT_EN
    check("rst_drop", drop_count, 8'd0);
`endif
    reset_n = 1'b1;
    step(10);
    check("idle_no_cmd", cmd_valid, 1'b0);

    // Table: one clean press per button, latency 2 + 4 + 1 + 1 = 8
    for (int v = 0; v < 5; v++) begin
      switch_bus = vecs[v].sw;
      step(3);
      btn = vecs[v].btn;
      sb.push_back({vecs[v].code, vecs[v].data});
      first = -1;
      for (int i = 1; i <= 20; i++) begin
        step();
        if (cmd_valid && first < 0) first = i;
      end
      check($sformatf("latency_v%0d", v), first, 8);
      btn = '0;
      step(20);
      wait_drain($sformatf("drain_v%0d", v));
    end

    // Bounce on COMPUTE: short pulses must not issue
    switch_bus = 8'h03;
    step(3);
    for (int j = 0; j < 8; j++) begin
      btn[2] = (j % 2 == 0);
      step(bounce[j]);
    end
    btn[2] = 1'b0;
    step(6);
    check("bounce_quiet", sb.size(), 0);
    btn[2] = 1'b1;
    sb.push_back({3'd2, 8'h03});
    step(20);
    btn[2] = 1'b0;
    step(20);
    wait_drain("drain_bounce");

    // Backpressure: held command ignores switch changes
    cmd_ready  = 1'b0;
    switch_bus = 8'h3C;
    step(3);
    btn[1] = 1'b1;
    sb.push_back({3'd1, 8'h3C});
    wait_valid("bp_valid", 30);
    switch_bus = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_hold", {cmd_valid, cmd_code, cmd_data}, {1'b1, 3'd1, 8'h3C});
    end
    btn[1] = 1'b0;
    cmd_ready = 1'b1;
    step();
    check("bp_transfer", cmd_valid, 1'b0);
    check("bp_sb", sb.size(), 0);
    step(20);

    // Priority/flush: NUM2 + DISPLAY + RESET together, only RESET issues
    switch_bus = 8'h55;
    step(3);
    btn = 5'b11010;
    sb.push_back({3'd4, 8'h00});
    step(20);
    btn = '0;
    step(20);
    wait_drain("drain_flush");
`ifdef MFU_CMD_DROP_COUNT_EN
    check("flush_drop", drop_count, 8'd2);
`endif

    // Async reset while a command is offered
    cmd_ready  = 1'b0;
    switch_bus = 8'h11;
    step(3);
    btn[0] = 1'b1;
    wait_valid("ar_valid", 30);
    btn[0] = 1'b0;
    step(2);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_valid_low", cmd_valid, 1'b0);
    check("ar_code_zero", cmd_code, 3'd0);
`ifdef MFU_CMD_DROP_COUNT_EN
    check("ar_drop_zero", drop_count, 8'd0);
`endif
    step(2);
    reset_n   = 1'b1;
    cmd_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (cmd_valid) seen++;
    end
    check("ar_no_cmd", seen, 0);

    // Re-press NUM1 while it is already pending behind a stalled DISPLAY
    cmd_ready  = 1'b0;
    switch_bus = 8'h9A;
    step(3);
    btn[3] = 1'b1;
    sb.push_back({3'd3, 8'h00});
    wait_valid("rp_valid", 30);
    btn[3] = 1'b0;
    step(10);
    sb.push_back({3'd0, 8'h9A});
    for (int r = 0; r < 2; r++) begin
      btn[0] = 1'b1;
      step(10);
      btn[0] = 1'b0;
      step(10);
    end
    check("rp_still_offer", {cmd_valid, cmd_code}, {1'b1, 3'd3});
    cmd_ready = 1'b1;
    step(10);
    wait_drain("drain_repress");
    step(20);
    check("rp_sb_empty", sb.size(), 0);
`ifdef MFU_CMD_DROP_COUNT_EN
    check("rp_drop", drop_count, 8'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
